// File: rtl/fir_mac_seq_if.sv
// FIR sequencer bundle: start/done control, tap store read port, ALU operand/result path, and FIR result.
// The slave modport is the sequencer; the master modport is its environment (stores, ALU, requester).
interface fir_mac_seq_if #(
  parameter int IDX_W = 3
);
  logic             start;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] tap_idx;
  logic             samp_sgn;
  logic [4:0]       samp_exp;
  logic [9:0]       samp_man;
  logic             coef_sgn;
  logic [4:0]       coef_exp;
  logic [9:0]       coef_man;
  logic             alu_a_sgn;
  logic [5:0]       alu_a_exp;
  logic [21:0]      alu_a_man;
  logic             alu_b_sgn;
  logic [5:0]       alu_b_exp;
  logic [21:0]      alu_b_man;
  logic             alu_add_muln;
  logic [5:0]       alu_y_exp;
  logic [21:0]      alu_y_man;
  logic             acc_sgn;
  logic [5:0]       acc_exp;
  logic [21:0]      acc_man;

  modport slave (
    input  start, samp_sgn, samp_exp, samp_man, coef_sgn, coef_exp, coef_man,
           alu_y_exp, alu_y_man,
    output busy, done, tap_idx,
           alu_a_sgn, alu_a_exp, alu_a_man, alu_b_sgn, alu_b_exp, alu_b_man,
           alu_add_muln, acc_sgn, acc_exp, acc_man
  );

  modport master (
    output start, samp_sgn, samp_exp, samp_man, coef_sgn, coef_exp, coef_man,
           alu_y_exp, alu_y_man,
    input  busy, done, tap_idx,
           alu_a_sgn, alu_a_exp, alu_a_man, alu_b_sgn, alu_b_exp, alu_b_man,
           alu_add_muln, acc_sgn, acc_exp, acc_man
  );
endinterface

// File: rtl/fir_mac_seq.sv
// FIR MAC sequencer: pipelined multiply burst into a product buffer, then serial adds; done NTAPS+ALU_LAT+(NTAPS-1)*(ALU_LAT+1)+1 cycles after start.
// No backpressure: start is a one-cycle request honoured only in IDLE, ignored while busy.
module fir_mac_seq #(
  parameter int NTAPS   = 8,
  parameter int IDX_W   = 3,
  parameter int ALU_LAT = 4
) (
  input logic          clk,
  input logic          rst,
  fir_mac_seq_if.slave bus
);
  typedef struct packed {
    logic        sgn;
    logic [5:0]  exp;
    logic [21:0] man;
  } fp29_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             sgn;
  } tag_t;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MUL       = 3'd1;
  localparam logic [2:0] S_ACC_ISSUE = 3'd2;
  localparam logic [2:0] S_ACC_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam int               CNT_W   = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(ALU_LAT);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NTAPS - 1);
  localparam logic [IDX_W-1:0] IDX1    = IDX_W'((NTAPS > 1) ? 1 : 0);

  logic [2:0]       state;
  logic             mul_iss;
  logic [IDX_W-1:0] tap_idx;
  logic [IDX_W-1:0] acc_j;
  logic [CNT_W-1:0] wait_cnt;
  logic             add_muln;
  logic             sum_sgn;
  fp29_t            op_a;
  fp29_t            op_b;
  fp29_t            acc_q;
  fp29_t            prod [NTAPS];
  tag_t             tag_q [ALU_LAT];

  tag_t             tag_out;
  fp29_t            samp_op;
  fp29_t            coef_op;
  fp29_t            y_tagged;
  fp29_t            acc_nxt;
  fp29_t            fwd0;
  fp29_t            fwd1;
  fp29_t            a_out;
  fp29_t            b_out;
  logic [IDX_W-1:0] nxt_idx;

  // Products may land in the same cycle they are first needed, so bypass the buffer.
  always_comb begin
    tag_out  = tag_q[ALU_LAT-1];
    samp_op  = {bus.samp_sgn, 1'b0, bus.samp_exp, 12'b0, bus.samp_man};
    coef_op  = {bus.coef_sgn, 1'b0, bus.coef_exp, 12'b0, bus.coef_man};
    y_tagged = {tag_out.sgn, bus.alu_y_exp, bus.alu_y_man};
    acc_nxt  = {sum_sgn, bus.alu_y_exp, bus.alu_y_man};
    fwd0     = (tag_out.vld && tag_out.idx == '0)   ? y_tagged : prod[0];
    fwd1     = (tag_out.vld && tag_out.idx == IDX1) ? y_tagged : prod[IDX1];
    nxt_idx  = (acc_j == LAST) ? acc_j : acc_j + 1'b1;
    a_out    = mul_iss ? samp_op : op_a;
    b_out    = mul_iss ? coef_op : op_b;
  end

  assign {bus.alu_a_sgn, bus.alu_a_exp, bus.alu_a_man} = a_out;
  assign {bus.alu_b_sgn, bus.alu_b_exp, bus.alu_b_man} = b_out;
  assign {bus.acc_sgn, bus.acc_exp, bus.acc_man}       = acc_q;
  assign bus.alu_add_muln = add_muln;
  assign bus.tap_idx      = tap_idx;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mul_iss  <= 1'b0;
      tap_idx  <= '0;
      acc_j    <= '0;
      wait_cnt <= '0;
      add_muln <= 1'b0;
      sum_sgn  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc_q    <= '0;
      for (int i = 0; i < ALU_LAT; i++) tag_q[i] <= '0;
      for (int i = 0; i < NTAPS; i++)   prod[i]  <= '0;
    end else begin
      // The ALU returns no sign, so each issue carries its index and product sign alongside.
      for (int i = ALU_LAT - 1; i > 0; i--) tag_q[i] <= tag_q[i-1];
      tag_q[0] <= '{mul_iss, tap_idx, bus.samp_sgn ^ bus.coef_sgn};
      if (tag_out.vld) prod[tag_out.idx] <= y_tagged;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_MUL;
            mul_iss <= 1'b1;
            tap_idx <= '0;
          end
        end
        S_MUL: begin
          if (mul_iss) begin
            if (tap_idx == LAST) mul_iss <= 1'b0;
            else                 tap_idx <= tap_idx + 1'b1;
          end
          if (tag_out.vld && tag_out.idx == LAST) begin
            if (NTAPS == 1) begin
              acc_q <= fwd0;
              state <= S_DONE;
            end else begin
              op_a     <= fwd0;
              op_b     <= fwd1;
              add_muln <= 1'b1;
              acc_j    <= IDX1;
              state    <= S_ACC_ISSUE;
            end
          end
        end
        S_ACC_ISSUE: begin
          add_muln <= 1'b0;
          sum_sgn  <= (op_a.exp >= op_b.exp) ? op_a.sgn : op_b.sgn;
          wait_cnt <= CNT_W'(1);
          state    <= S_ACC_WAIT;
        end
        S_ACC_WAIT: begin
          if (wait_cnt == LAT_CNT) begin
            if (acc_j == LAST) begin
              acc_q <= acc_nxt;
              op_a  <= '0;
              op_b  <= '0;
              state <= S_DONE;
            end else begin
              op_a     <= acc_nxt;
              op_b     <= prod[nxt_idx];
              add_muln <= 1'b1;
              acc_j    <= nxt_idx;
              state    <= S_ACC_ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: behavioural ALU with fixed latency, tap stores, and a fold-style FIR reference.
module tb_fir_mac_seq;
  localparam int NTAPS     = 8;
  localparam int IDX_W     = 3;
  localparam int ALU_LAT   = 4;
  localparam int DONE_CYC  = NTAPS + ALU_LAT + (NTAPS - 1) * (ALU_LAT + 1) + 1;
  localparam int FIRST_ADD = NTAPS + ALU_LAT + 1;
  localparam int NCYC      = 58;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_seq_if #(.IDX_W(IDX_W)) bus ();
  fir_mac_seq #(.NTAPS(NTAPS), .IDX_W(IDX_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] samp_mem [NTAPS];
  logic [15:0] coef_mem [NTAPS];
  assign bus.samp_sgn = samp_mem[bus.tap_idx][15];
  assign bus.samp_exp = samp_mem[bus.tap_idx][14:10];
  assign bus.samp_man = samp_mem[bus.tap_idx][9:0];
  assign bus.coef_sgn = coef_mem[bus.tap_idx][15];
  assign bus.coef_exp = coef_mem[bus.tap_idx][14:10];
  assign bus.coef_man = coef_mem[bus.tap_idx][9:0];

  function automatic logic [28:0] ext16(input logic [15:0] h);
    return {h[15], 1'b0, h[14:10], 12'b0, h[9:0]};
  endfunction

  // Magnitude-only ALU arithmetic returning {exp, man}.
  function automatic logic [27:0] alu_fn(input logic add, input logic [28:0] a, input logic [28:0] b);
    logic [5:0]  ea, eb, eh;
    logic [21:0] ma, mb, ml, sh;
    logic [43:0] p;
    logic [22:0] s;
    int          d;
    ea = a[27:22]; eb = b[27:22]; ma = a[21:0]; mb = b[21:0];
    if (!add) begin
      if ((ea == 0 && ma == 0) || (eb == 0 && mb == 0)) return 28'd0;
      p = {22'd0, ma | ((ea != 0) ? 22'd1024 : 22'd0)} * {22'd0, mb | ((eb != 0) ? 22'd1024 : 22'd0)};
      return {6'(ea + eb), p[21:0]};
    end
    if (ea == 0 && ma == 0) return {eb, mb};
    if (ea >= eb) begin eh = ea; s = {1'b0, ma}; ml = mb; d = int'(ea - eb); end
    else          begin eh = eb; s = {1'b0, mb}; ml = ma; d = int'(eb - ea); end
    sh = (d > 21) ? 22'd0 : (ml >> d);
    s  = s + {1'b0, sh};
    if (s[22]) return {6'(eh + 6'd1), s[22:1]};
    return {eh, s[21:0]};
  endfunction

  logic [27:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(bus.alu_add_muln,
                          {bus.alu_a_sgn, bus.alu_a_exp, bus.alu_a_man},
                          {bus.alu_b_sgn, bus.alu_b_exp, bus.alu_b_man});
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {bus.alu_y_exp, bus.alu_y_man} = alu_pipe[ALU_LAT-1];

  // Reference: products, then a left fold where the sum takes the sign of the larger-exponent operand.
  logic [28:0] exp_prod [NTAPS];
  logic [28:0] exp_part [NTAPS];
  logic [28:0] exp_acc;
  task automatic compute_expected();
    logic [28:0] acc;
    for (int i = 0; i < NTAPS; i++)
      exp_prod[i] = {samp_mem[i][15] ^ coef_mem[i][15], alu_fn(1'b0, ext16(samp_mem[i]), ext16(coef_mem[i]))};
    acc = exp_prod[0];
    exp_part[0] = acc;
    for (int j = 1; j < NTAPS; j++) begin
      acc = {(acc[27:22] >= exp_prod[j][27:22]) ? acc[28] : exp_prod[j][28], alu_fn(1'b1, acc, exp_prod[j])};
      exp_part[j] = acc;
    end
    exp_acc = acc;
  endtask

  logic        tr_add  [NCYC];
  logic        tr_busy [NCYC];
  logic        tr_done [NCYC];
  logic [IDX_W-1:0] tr_idx [NCYC];
  logic [28:0] tr_a [NCYC];
  logic [28:0] tr_b [NCYC];
  logic [28:0] tr_acc [NCYC];
  logic [28:0] acc_at_done;
  int          done_cnt;
  int          done_cyc;

  task automatic record(input int c);
    tr_add[c]  = bus.alu_add_muln;
    tr_busy[c] = bus.busy;
    tr_done[c] = bus.done;
    tr_idx[c]  = bus.tap_idx;
    tr_a[c]    = {bus.alu_a_sgn, bus.alu_a_exp, bus.alu_a_man};
    tr_b[c]    = {bus.alu_b_sgn, bus.alu_b_exp, bus.alu_b_man};
    tr_acc[c]  = {bus.acc_sgn, bus.acc_exp, bus.acc_man};
  endtask

  // Start is raised in cycle 0; the loop length bounds every wait for done.
  task automatic run_op(input int repulse, input int rst_at);
    done_cnt = 0;
    done_cyc = -1;
    acc_at_done = 'x;
    @(posedge clk); #1;
    record(0);
    bus.start = 1'b1;
    for (int c = 1; c < NCYC; c++) begin
      @(posedge clk); #1;
      record(c);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; acc_at_done = tr_acc[c]; end
      end
      bus.start = (c == repulse);
      rst       = (c == rst_at);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NTAPS; i++) begin
      samp_mem[i] = 16'($urandom);
      coef_mem[i] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.alu_add_muln} !== 3'b000)
      $display("FAIL reset_ctrl: got %b required 000", {bus.busy, bus.done, bus.alu_add_muln});
    else n_pass++;
    n_checks++;
    if (bus.tap_idx !== '0) $display("FAIL reset_tap_idx: got %0d required 0", bus.tap_idx);
    else n_pass++;
    n_checks++;
    if ({bus.alu_a_sgn, bus.alu_a_exp, bus.alu_a_man, bus.alu_b_sgn, bus.alu_b_exp, bus.alu_b_man} !== 58'd0)
      $display("FAIL reset_operands: got a=%h b=%h required 0", bus.alu_a_man, bus.alu_b_man);
    else n_pass++;
    n_checks++;
    if ({bus.acc_sgn, bus.acc_exp, bus.acc_man} !== 29'd0)
      $display("FAIL reset_acc: got %h required 0", {bus.acc_sgn, bus.acc_exp, bus.acc_man});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_timing();
    logic eb, ed, ea;
    fill_random();
    compute_expected();
    run_op(-1, -1);
    for (int c = 0; c < NCYC; c++) begin
      eb = (c >= 1 && c <= DONE_CYC);
      ed = (c == DONE_CYC);
      ea = 1'b0;
      for (int j = 1; j < NTAPS; j++) if (c == FIRST_ADD + (j - 1) * (ALU_LAT + 1)) ea = 1'b1;
      n_checks++;
      if ({tr_busy[c], tr_done[c], tr_add[c]} !== {eb, ed, ea})
        $display("FAIL ctrl_cyc%0d: busy/done/add got %b required %b", c, {tr_busy[c], tr_done[c], tr_add[c]}, {eb, ed, ea});
      else n_pass++;
    end
    for (int k = 0; k < NTAPS; k++) begin
      n_checks++;
      if (tr_idx[k+1] !== IDX_W'(k)) $display("FAIL mul_tap_idx%0d: got %0d required %0d", k, tr_idx[k+1], k);
      else n_pass++;
      n_checks++;
      if ({tr_a[k+1], tr_b[k+1]} !== {ext16(samp_mem[k]), ext16(coef_mem[k])})
        $display("FAIL mul_operands%0d: got a=%h b=%h required a=%h b=%h", k, tr_a[k+1], tr_b[k+1],
                 ext16(samp_mem[k]), ext16(coef_mem[k]));
      else n_pass++;
    end
    n_checks++;
    if (acc_at_done !== exp_acc) $display("FAIL timing_acc: got %h required %h", acc_at_done, exp_acc);
    else n_pass++;
  endtask

  // pat: 0 all zero, 1 unity*0x0200, 2 alternating sign, 3 random
  task automatic test_products(input int pat);
    int c;
    for (int i = 0; i < NTAPS; i++) begin
      case (pat)
        0:       begin samp_mem[i] = 16'h0000; coef_mem[i] = 16'h0000; end
        1:       begin samp_mem[i] = 16'h3C00; coef_mem[i] = 16'h0200; end
        2:       begin samp_mem[i] = (i % 2 == 1) ? 16'hBC00 : 16'h3C00; coef_mem[i] = 16'h0200; end
        default: begin samp_mem[i] = 16'($urandom); coef_mem[i] = 16'($urandom); end
      endcase
    end
    compute_expected();
    run_op(-1, -1);
    n_checks++;
    if (done_cyc != DONE_CYC || done_cnt != 1)
      $display("FAIL p%0d_done: got cyc %0d count %0d required cyc %0d count 1", pat, done_cyc, done_cnt, DONE_CYC);
    else n_pass++;
    for (int j = 1; j < NTAPS; j++) begin
      c = FIRST_ADD + (j - 1) * (ALU_LAT + 1);
      n_checks++;
      if (tr_b[c] !== exp_prod[j]) $display("FAIL p%0d_prod%0d: got %h required %h", pat, j, tr_b[c], exp_prod[j]);
      else n_pass++;
      n_checks++;
      if (tr_a[c] !== exp_part[j-1]) $display("FAIL p%0d_opa%0d: got %h required %h", pat, j, tr_a[c], exp_part[j-1]);
      else n_pass++;
    end
    n_checks++;
    if (acc_at_done !== exp_acc) $display("FAIL p%0d_acc: got %h required %h", pat, acc_at_done, exp_acc);
    else n_pass++;
    if (pat < 2) begin
      n_checks++;
      if (acc_at_done[28] !== 1'b0) $display("FAIL p%0d_acc_sgn: got %b required 0", pat, acc_at_done[28]);
      else n_pass++;
    end
    if (pat == 0) begin
      n_checks++;
      if (acc_at_done[21:0] !== 22'd0) $display("FAIL p0_acc_man: got %h required 0", acc_at_done[21:0]);
      else n_pass++;
    end
  endtask

  task automatic test_restart_ignored();
    fill_random();
    compute_expected();
    run_op(10, -1);
    n_checks++;
    if (done_cyc != DONE_CYC || done_cnt != 1)
      $display("FAIL restart_done: got cyc %0d count %0d required cyc %0d count 1", done_cyc, done_cnt, DONE_CYC);
    else n_pass++;
    for (int k = 0; k < NTAPS; k++) begin
      n_checks++;
      if (tr_idx[k+1] !== IDX_W'(k)) $display("FAIL restart_tap_idx%0d: got %0d required %0d", k, tr_idx[k+1], k);
      else n_pass++;
    end
    n_checks++;
    if (tr_busy[DONE_CYC+1] !== 1'b0) $display("FAIL restart_idle: busy got %b required 0", tr_busy[DONE_CYC+1]);
    else n_pass++;
    n_checks++;
    if (acc_at_done !== exp_acc) $display("FAIL restart_acc: got %h required %h", acc_at_done, exp_acc);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    fill_random();
    run_op(-1, 20);
    n_checks++;
    if ({tr_busy[21], tr_done[21], tr_add[21], tr_idx[21]} !== '0)
      $display("FAIL midrst_ctrl: got busy=%b done=%b add=%b idx=%0d required 0", tr_busy[21], tr_done[21], tr_add[21], tr_idx[21]);
    else n_pass++;
    n_checks++;
    if ({tr_a[21], tr_b[21], tr_acc[21]} !== 87'd0)
      $display("FAIL midrst_data: got a=%h b=%h acc=%h required 0", tr_a[21], tr_b[21], tr_acc[21]);
    else n_pass++;
    n_checks++;
    if (done_cnt != 0) $display("FAIL midrst_no_done: got %0d done pulses required 0", done_cnt);
    else n_pass++;
    fill_random();
    compute_expected();
    run_op(-1, -1);
    n_checks++;
    if (done_cyc != DONE_CYC) $display("FAIL midrst_rerun_done: got cyc %0d required %0d", done_cyc, DONE_CYC);
    else n_pass++;
    n_checks++;
    if (acc_at_done !== exp_acc) $display("FAIL midrst_rerun_acc: got %h required %h", acc_at_done, exp_acc);
    else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin samp_mem[i] = '0; coef_mem[i] = '0; end
    test_reset();
    test_timing();
    test_products(0);
    test_products(1);
    test_products(2);
    for (int r = 0; r < 4; r++) test_products(3);
    test_restart_ignored();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
